cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Arbitrates 32-bit command words from two requesters: the SPI path and the logic-analyser/host path.
- Sequences each granted word into the controller core's command interface: stable cmd_data, then a latch_data or control_trigger strobe long enough to pass the core's 3-cycle input filter.
- Trigger commands also wait for update_cycle_complete, with a timeout.
- Sits between the async-crossed command sources and system_controller, in the core clock domain.

Parameters:
- SETUP_CYCLES, 2: cycles cmd_data is stable before the strobe (≥1).
- PULSE_CYCLES, 4: strobe high time in cycles (≥3).
- HOLD_CYCLES, 2: cycles cmd_data is held after the strobe falls (≥1).
- TIMEOUT_CYCLES, 4096: maximum wait for update_cycle_complete.
- CNT_WIDTH, 13: shared down-counter width; must hold max(all cycle parameters).

Ports:
- clock, input, 1: core clock.
- reset_n, input, 1: synchronous active-low reset.
- spi_cmd_valid, input, 1: SPI requester has a word.
- spi_cmd_data, input, 32: SPI command word.
- spi_cmd_ready, output, 1: SPI word accepted this cycle.
- la_cmd_valid, input, 1: LA requester has a word.
- la_cmd_data, input, 32: LA command word.
- la_cmd_ready, output, 1: LA word accepted this cycle.
- cmd_data, output, 32: word presented to the core.
- latch_data, output, 1: data strobe to the core.
- control_trigger, output, 1: trigger strobe to the core.
- update_cycle_complete, input, 1: level from the backend cycle controller.
- timeout_clr, input, 1: clears timeout_err.
- busy, output, 1: high whenever state is not IDLE.
- timeout_err, output, 1: sticky timeout flag.

Behaviour:
- Reset: one clock with reset_n=0 at any state forces state=IDLE.
  - All outputs 0: cmd_data=0, latch_data=0, control_trigger=0, both readies=0, busy=0, timeout_err=0.
  - last_grant=LA, so the first tie goes to SPI.
  - The counter and edge-detect register are also cleared.
  - A strobe in progress drops on the reset cycle.
- Handshake:
  - A transfer occurs when valid&ready.
  - ready is combinational and high only in IDLE for the granted source; at most one ready is high per cycle.
  - A requester must hold valid and data stable until ready.
- Arbitration in IDLE:
  - Only one source valid: that source is granted.
  - Both valid: grant the source that is not last_grant (round robin).
  - last_grant updates on each transfer.
- Transfer at cycle T: word registered into cmd_data at T+1; state becomes SETUP; counter loaded.
- States, outputs and transitions:
  - IDLE: strobes low; busy=0; cmd_data retains the last word.
  - SETUP: SETUP_CYCLES cycles, then STROBE.
  - STROBE: PULSE_CYCLES cycles.
    - cmd_data[31]=0: latch_data=1.
    - cmd_data[31]=1: control_trigger=1.
    - Then HOLD.
  - HOLD: HOLD_CYCLES cycles, strobes low.
    - bit31=0: go to IDLE.
    - bit31=1: go to WAIT_DONE and load the counter with TIMEOUT_CYCLES.
  - WAIT_DONE: leave on a rising edge of update_cycle_complete (previous sample 0, current 1) and go to IDLE. If the counter expires first, set timeout_err and go to IDLE.
- Strobe timing: registered; exactly PULSE_CYCLES cycles high. First strobe-high cycle = T+1+SETUP_CYCLES.
- Throughput: a new transfer can happen in the first IDLE cycle after HOLD or WAIT_DONE; no back-to-back overlap.
- update_cycle_complete: edges outside WAIT_DONE are ignored. If it is already high on WAIT_DONE entry, no edge is counted; the block waits for 0→1.
- Timeout precedence: rising edge and counter expiry in the same cycle counts as completion, not timeout.
- timeout_err: set has priority over timeout_clr in the same cycle; otherwise timeout_clr=1 clears it.
- Full 32-bit word is passed unchanged, including bit 31.

Optional Feature:
- Macro CMD_SEQ_FIXED_PRIORITY_EN.
- Defined: fixed priority, SPI always wins a tie; last_grant is not implemented.
- Undefined: round robin as specified above.
- Ports and timing are otherwise identical.

Test Plan:
- Reset, then single SPI word 0x0000_1234 → spi_cmd_ready for 1 cycle; cmd_data=0x0000_1234 next cycle; latch_data high exactly 4 cycles starting 3 cycles after transfer; control_trigger stays 0; busy high 8 cycles; then IDLE.
- Both valid continuously, SPI=0x1, LA=0x2 → grant order SPI, LA, SPI, LA; cmd_data sequence 1,2,1,2.
  - With CMD_SEQ_FIXED_PRIORITY_EN defined: always 0x1 while SPI is valid.
- LA word 0x8000_0005 with update_cycle_complete rising 20 cycles after HOLD → control_trigger high 4 cycles; latch_data 0; busy drops the cycle after the edge; timeout_err=0.
- Trigger word with update_cycle_complete stuck at 0 → after 4096 WAIT_DONE cycles timeout_err=1 and state IDLE; timeout_clr pulse → timeout_err=0.
- reset_n=0 for one cycle mid-STROBE → latch_data=0, cmd_data=0, busy=0 next cycle; the pending LA valid is granted on the first post-reset IDLE cycle if SPI is idle.
- update_cycle_complete already high on WAIT_DONE entry, falling after 5 cycles and rising after 10 → completion only on that later rising edge.

Source files
------------

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: arbitrates SPI/LA command words and strobes them into the core with setup/pulse/hold timing.
// Define CMD_SEQ_FIXED_PRIORITY_EN for fixed SPI-first priority instead of round robin.
module cmd_sequencer #(
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 13
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        spi_cmd_valid,
  input  logic [31:0] spi_cmd_data,
  output logic        spi_cmd_ready,
  input  logic        la_cmd_valid,
  input  logic [31:0] la_cmd_data,
  output logic        la_cmd_ready,
  output logic [31:0] cmd_data,
  output logic        latch_data,
  output logic        control_trigger,
  input  logic        update_cycle_complete,
  input  logic        timeout_clr,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0] cmd_q, cmd_d;
  logic latch_q, latch_d, trig_q, trig_d, err_q, err_d, uc_q;
  logic gnt_spi, cnt_zero, rise;
`ifdef CMD_SEQ_FIXED_PRIORITY_EN
  assign gnt_spi = spi_cmd_valid;
`else
  // last_q=1 means the LA source won the previous transfer
  logic last_q, last_d;
  assign gnt_spi = spi_cmd_valid & (!la_cmd_valid | last_q);
`endif
  assign spi_cmd_ready   = (state_q == IDLE) & gnt_spi;
  assign la_cmd_ready    = (state_q == IDLE) & la_cmd_valid & !gnt_spi;
  assign cnt_zero        = cnt_q == '0;
  assign rise            = update_cycle_complete & !uc_q;
  assign cmd_data        = cmd_q;
  assign latch_data      = latch_q;
  assign control_trigger = trig_q;
  assign busy            = state_q != IDLE;
  assign timeout_err     = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    cmd_d   = cmd_q;
    err_d   = timeout_clr ? 1'b0 : err_q;
`ifndef CMD_SEQ_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: if (spi_cmd_ready | la_cmd_ready) begin
        state_d = SETUP;
        cnt_d   = CNT_WIDTH'(SETUP_CYCLES - 1);
        cmd_d   = spi_cmd_ready ? spi_cmd_data : la_cmd_data;
`ifndef CMD_SEQ_FIXED_PRIORITY_EN
        last_d  = la_cmd_ready;
`endif
      end
      SETUP: if (cnt_zero) begin
        state_d = STROBE;
        cnt_d   = CNT_WIDTH'(PULSE_CYCLES - 1);
      end
      STROBE: if (cnt_zero) begin
        state_d = HOLD;
        cnt_d   = CNT_WIDTH'(HOLD_CYCLES - 1);
      end
      HOLD: if (cnt_zero) begin
        state_d = cmd_q[31] ? WAIT_DONE : IDLE;
        cnt_d   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
      end
      WAIT_DONE: if (rise) begin
        state_d = IDLE;
      end else if (cnt_zero) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    latch_d = (state_d == STROBE) & !cmd_d[31];
    trig_d  = (state_d == STROBE) & cmd_d[31];
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      latch_q <= 1'b0;
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
      uc_q    <= 1'b0;
`ifndef CMD_SEQ_FIXED_PRIORITY_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      latch_q <= latch_d;
      trig_q  <= trig_d;
      err_q   <= err_d;
      uc_q    <= update_cycle_complete;
`ifndef CMD_SEQ_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: per-cycle vector table for cmd_sequencer, built from transfer/wait helpers and applied in a loop.
module tb_cmd_sequencer;
  logic clock = 1'b0;
  logic reset_n, spi_cmd_valid, la_cmd_valid, update_cycle_complete, timeout_clr;
  logic [31:0] spi_cmd_data, la_cmd_data, cmd_data;
  logic spi_cmd_ready, la_cmd_ready, latch_data, control_trigger, busy, timeout_err;
  always #5 clock = ~clock;
  cmd_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .spi_cmd_valid(spi_cmd_valid), .spi_cmd_data(spi_cmd_data), .spi_cmd_ready(spi_cmd_ready),
    .la_cmd_valid(la_cmd_valid), .la_cmd_data(la_cmd_data), .la_cmd_ready(la_cmd_ready),
    .cmd_data(cmd_data), .latch_data(latch_data), .control_trigger(control_trigger),
    .update_cycle_complete(update_cycle_complete), .timeout_clr(timeout_clr),
    .busy(busy), .timeout_err(timeout_err)
  );
  // expected = {spi_rdy, la_rdy, cmd_data, latch, trigger, busy, timeout_err}
  typedef struct {
    logic rst_n; logic sv; logic [31:0] sd; logic lv; logic [31:0] ld;
    logic uc; logic clr; logic chk; logic [37:0] exp;
  } vec_t;
  vec_t q[$];
  logic [31:0] last_word;
  logic err_e;
  int checks = 0, errors = 0;
  function automatic logic [37:0] ex(logic sr, logic lr, logic [31:0] c, logic l, logic t, logic b, logic e);
    return {sr, lr, c, l, t, b, e};
  endfunction
  task automatic add(input logic rn, input logic sv, input logic [31:0] sd, input logic lv,
                     input logic [31:0] ld, input logic uc, input logic clr, input logic chk,
                     input logic [37:0] e);
    vec_t v;
    v.rst_n = rn; v.sv = sv; v.sd = sd; v.lv = lv; v.ld = ld;
    v.uc = uc; v.clr = clr; v.chk = chk; v.exp = e;
    q.push_back(v);
  endtask
  // one transfer cycle plus SETUP(2), STROBE(4), HOLD(2)
  task automatic xfer(input logic sv, input logic [31:0] sd, input logic lv, input logic [31:0] ld,
                      input logic to_spi, input logic hold, input logic uc);
    logic [31:0] w;
    logic s;
    w = to_spi ? sd : ld;
    add(1'b1, sv, sd, lv, ld, uc, 1'b0, 1'b1, ex(to_spi, !to_spi, last_word, 1'b0, 1'b0, 1'b0, err_e));
    for (int k = 1; k <= 8; k++) begin
      s = (k >= 3) && (k <= 6);
      add(1'b1, hold & sv, sd, hold & lv, ld, uc, 1'b0, 1'b1,
          ex(1'b0, 1'b0, w, s & !w[31], s & w[31], 1'b1, err_e));
    end
    last_word = w;
  endtask
  task automatic idle(input logic uc, input logic clr);
    add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, uc, clr, 1'b1, ex(1'b0, 1'b0, last_word, 1'b0, 1'b0, 1'b0, err_e));
  endtask
  task automatic waitc(input int n, input logic uc, input logic clr);
    for (int k = 0; k < n; k++)
      add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, uc, clr, 1'b1, ex(1'b0, 1'b0, last_word, 1'b0, 1'b0, 1'b1, err_e));
  endtask
  task automatic rst();
    add(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
    last_word = 32'h0;
    err_e = 1'b0;
  endtask
  initial begin
    logic [37:0] got;
    last_word = 32'h0;
    err_e = 1'b0;
    rst();
    idle(1'b0, 1'b0);
    xfer(1'b1, 32'h0000_1234, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    rst();
`ifdef CMD_SEQ_FIXED_PRIORITY_EN
    for (int k = 0; k < 4; k++) xfer(1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 1'b1, 1'b0);
`else
    for (int k = 0; k < 4; k++) xfer(1'b1, 32'h1, 1'b1, 32'h2, k % 2 == 0, 1'b1, 1'b0);
`endif
    idle(1'b0, 1'b0);
    // trigger completes on edge 20 cycles into WAIT_DONE
    xfer(1'b0, 32'h0, 1'b1, 32'h8000_0005, 1'b0, 1'b0, 1'b0);
    waitc(20, 1'b0, 1'b0);
    waitc(1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    // timeout; clear asserted on the expiry cycle loses to the set
    xfer(1'b1, 32'h8000_0009, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    waitc(4095, 1'b0, 1'b0);
    waitc(1, 1'b0, 1'b1);
    err_e = 1'b1;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    err_e = 1'b0;
    idle(1'b0, 1'b0);
    // level already high on entry: only the later rising edge completes
    xfer(1'b1, 32'h8000_0011, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    waitc(5, 1'b1, 1'b0);
    waitc(10, 1'b0, 1'b0);
    waitc(1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    // reset in the second STROBE cycle with LA waiting
    add(1'b1, 1'b1, 32'h77, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b0, last_word, 1'b0, 1'b0, 1'b0, 1'b0));
    add(1'b1, 1'b0, 32'h0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0));
    add(1'b1, 1'b0, 32'h0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0));
    add(1'b1, 1'b0, 32'h0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 32'h77, 1'b1, 1'b0, 1'b1, 1'b0));
    add(1'b0, 1'b0, 32'h0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 32'h77, 1'b1, 1'b0, 1'b1, 1'b0));
    last_word = 32'h0;
    xfer(1'b0, 32'h0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      reset_n = q[i].rst_n;
      spi_cmd_valid = q[i].sv; spi_cmd_data = q[i].sd;
      la_cmd_valid = q[i].lv; la_cmd_data = q[i].ld;
      update_cycle_complete = q[i].uc; timeout_clr = q[i].clr;
      #1;
      if (q[i].chk) begin
        got = {spi_cmd_ready, la_cmd_ready, cmd_data, latch_data, control_trigger, busy, timeout_err};
        checks++;
        if (got !== q[i].exp) begin
          errors++;
          $display("FAIL vec%0d {srdy,lrdy,cmd,latch,trig,busy,err}: got %h expected %h", i, got, q[i].exp);
        end
      end
      @(posedge clock);
      #1;
      if (!q[i].rst_n) begin
        checks++;
        if ({cmd_data, latch_data, control_trigger, busy, timeout_err} !== 36'h0) begin
          errors++;
          $display("FAIL reset vec%0d: cmd=%h latch=%b trig=%b busy=%b err=%b", i, cmd_data, latch_data, control_trigger, busy, timeout_err);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
